// File: rtl/tetris_board_engine.sv
// ---------------------------------------------------------------------------
// tetris_board_engine
//   Parametrised playfield store for the Tetris datapath. It holds a COLS x ROWS
//   grid of 3-bit block colours, where 0 means EMPTY and y = 0 is the top row.
//   The block provides:
//     - a registered collision check for a candidate 4-cell piece,
//     - a lock path that writes a piece into the grid (valid/ready),
//     - a multi-cycle line-clear FSM that reports the lines cleared per lock,
//     - a combinational read port for the renderer.
//
//   Optional feature:
//     BOARD_STATS_EN  When defined, adds a saturating 16-bit total_lines
//                     counter that accumulates clr_lines on every clr_done.
//
//   Ports:
//     Clk, Reset           clock; synchronous active-high reset
//     rd_x, rd_y           renderer address
//     rd_color             combinational cell colour; EMPTY when the address
//                          is out of range
//     chk_valid/x/y        collision-check request (cell k at [k*CW +: CW])
//     chk_done, chk_ok     check result, one cycle after the request
//     lock_valid/x/y/color piece lock request
//     lock_ready           high only in IDLE
//     busy                 high in every state other than IDLE
//     clr_done, clr_lines  end-of-clear pulse; line count for the last lock
//     game_over            sticky; set by an out-of-bounds or overlapping lock
//     total_lines          lifetime line count (BOARD_STATS_EN only)
// ---------------------------------------------------------------------------
module tetris_board_engine #(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 20,
    parameter int unsigned CW   = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CW-1:0]     rd_x,
    input  logic [CW-1:0]     rd_y,
    output logic [2:0]        rd_color,
    input  logic              chk_valid,
    input  logic [4*CW-1:0]   chk_x,
    input  logic [4*CW-1:0]   chk_y,
    output logic              chk_done,
    output logic              chk_ok,
    input  logic              lock_valid,
    output logic              lock_ready,
    input  logic [4*CW-1:0]   lock_x,
    input  logic [4*CW-1:0]   lock_y,
    input  logic [2:0]        lock_color,
    output logic              busy,
    output logic              clr_done,
    output logic [2:0]        clr_lines,
    output logic              game_over
`ifdef BOARD_STATS_EN
    ,
    output logic [15:0]       total_lines
`endif
);

    // Index widths that exactly address the grid dimensions.
    localparam int unsigned XW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned YW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // One extra bit so that COLS or ROWS equal to 2**CW still compares correctly.
    localparam logic [CW:0] COLS_L = (CW+1)'(COLS);
    localparam logic [CW:0] ROWS_L = (CW+1)'(ROWS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state_q,     state_d;
    logic [YW-1:0] r_q,         r_d;
    logic [2:0]    n_q,         n_d;
    logic [2:0]    grid_q [ROWS][COLS];
    logic [2:0]    grid_d [ROWS][COLS];
    logic          chk_done_q,  chk_done_d;
    logic          chk_ok_q,    chk_ok_d;
    logic          clr_done_q,  clr_done_d;
    logic [2:0]    clr_lines_q, clr_lines_d;
    logic          game_over_q, game_over_d;

    logic [CW-1:0] cx, cy, lx, ly;
    logic          row_full;

    // Bounds test for one cell coordinate pair.
    function automatic logic in_bounds(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return ({1'b0, x} < COLS_L) && ({1'b0, y} < ROWS_L);
    endfunction

    // Current colour of a cell; EMPTY outside the playfield.
    function automatic logic [2:0] cell_at(input logic [CW-1:0] x, input logic [CW-1:0] y);
        logic [2:0] c;
        c = 3'd0;
        if (in_bounds(x, y)) begin
            c = grid_q[y[YW-1:0]][x[XW-1:0]];
        end
        return c;
    endfunction

    // Renderer read port; sees the live grid, including mid-clear frames.
    assign rd_color = cell_at(rd_x, rd_y);

    // Row under the scan pointer has no EMPTY cell.
    always_comb begin
        row_full = 1'b1;
        for (int xx = 0; xx < COLS; xx++) begin
            if (grid_q[r_q][xx] == 3'd0) begin
                row_full = 1'b0;
            end
        end
    end

    // Next-state, grid update and registered-output logic.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        n_d         = n_q;
        grid_d      = grid_q;
        chk_done_d  = chk_valid;
        chk_ok_d    = 1'b0;
        clr_done_d  = 1'b0;
        clr_lines_d = clr_lines_q;
        game_over_d = game_over_q;
        cx          = '0;
        cy          = '0;
        lx          = '0;
        ly          = '0;

        // Check against the pre-lock grid; any busy state forces a reject.
        if (chk_valid && (state_q == IDLE)) begin
            chk_ok_d = 1'b1;
            for (int k = 0; k < 4; k++) begin
                cx = chk_x[k*CW +: CW];
                cy = chk_y[k*CW +: CW];
                if (!in_bounds(cx, cy) || (cell_at(cx, cy) != 3'd0)) begin
                    chk_ok_d = 1'b0;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (lock_valid) begin
                    // Occupancy is judged on the pre-lock grid, so duplicate
                    // cells within one piece never flag game_over.
                    for (int k = 0; k < 4; k++) begin
                        lx = lock_x[k*CW +: CW];
                        ly = lock_y[k*CW +: CW];
                        if (!in_bounds(lx, ly)) begin
                            game_over_d = 1'b1;
                        end else begin
                            if (cell_at(lx, ly) != 3'd0) begin
                                game_over_d = 1'b1;
                            end
                            grid_d[ly[YW-1:0]][lx[XW-1:0]] = lock_color;
                        end
                    end
                    state_d = SCAN;
                    r_d     = YW'(ROWS - 1);
                    n_d     = 3'd0;
                end
            end

            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (r_q != '0) begin
                    r_d = r_q - YW'(1);
                end else begin
                    // Result is published on entry so it is valid with the pulse.
                    state_d     = DONE;
                    clr_done_d  = 1'b1;
                    clr_lines_d = n_q;
                end
            end

            SHIFT: begin
                // Drop rows 0..r-1 by one; r stays put so the new row is rescanned.
                for (int yy = 1; yy < ROWS; yy++) begin
                    if (YW'(yy) <= r_q) begin
                        for (int xx = 0; xx < COLS; xx++) begin
                            grid_d[yy][xx] = grid_q[yy-1][xx];
                        end
                    end
                end
                for (int xx = 0; xx < COLS; xx++) begin
                    grid_d[0][xx] = 3'd0;
                end
                n_d     = (n_q == 3'd4) ? 3'd4 : (n_q + 3'd1);
                state_d = SCAN;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grid registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            n_q         <= 3'd0;
            chk_done_q  <= 1'b0;
            chk_ok_q    <= 1'b0;
            clr_done_q  <= 1'b0;
            clr_lines_q <= 3'd0;
            game_over_q <= 1'b0;
            for (int yy = 0; yy < ROWS; yy++) begin
                for (int xx = 0; xx < COLS; xx++) begin
                    grid_q[yy][xx] <= 3'd0;
                end
            end
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            n_q         <= n_d;
            chk_done_q  <= chk_done_d;
            chk_ok_q    <= chk_ok_d;
            clr_done_q  <= clr_done_d;
            clr_lines_q <= clr_lines_d;
            game_over_q <= game_over_d;
            grid_q      <= grid_d;
        end
    end

`ifdef BOARD_STATS_EN
    logic [15:0] total_lines_q, total_lines_d;
    logic [16:0] total_sum;

    // Saturating accumulation of lines cleared, updated with clr_done.
    always_comb begin
        total_sum     = {1'b0, total_lines_q} + 17'(clr_lines_d);
        total_lines_d = total_lines_q;
        if (clr_done_d) begin
            total_lines_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            total_lines_q <= 16'd0;
        end else begin
            total_lines_q <= total_lines_d;
        end
    end

    assign total_lines = total_lines_q;
`endif

    assign chk_done   = chk_done_q;
    assign chk_ok     = chk_ok_q;
    assign clr_done   = clr_done_q;
    assign clr_lines  = clr_lines_q;
    assign game_over  = game_over_q;
    assign busy       = (state_q != IDLE);
    assign lock_ready = (state_q == IDLE);

endmodule
